io_out_fifo: RTL and testbench

IO_OUT_FIFO -- requirements
Module: io_out_fifo

---
 rtl/io_out_fifo_pkg.sv | 19 +
 rtl/io_out_fifo_ram.sv | 18 +
 rtl/io_out_fifo.sv | 72 +++++++
 tb/tb_io_out_fifo.sv | 130 +++++++++++++
 4 files changed

// File: rtl/io_out_fifo_pkg.sv
// io_out_fifo_pkg: width helpers and the {tag, data} entry layout shared by the output FIFO.
package io_out_fifo_pkg;
  function automatic int nbd_f(input int nbmant, input int nbexpo);
    return nbmant + nbexpo + 1;
  endfunction
  function automatic int nba_f(input int nuioou);
    return $clog2(nuioou);
  endfunction
  function automatic int nbc_f(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int DEF_NBA = nba_f(2);
  localparam int DEF_NBD = nbd_f(16, 6);
  // Entry at default widths; parameterised instances use the same {tag, data} ordering.
  typedef struct packed {
    logic [DEF_NBA-1:0] tag;
    logic [DEF_NBD-1:0] data;
  } entry_t;
endpackage

// File: rtl/io_out_fifo_ram.sv
// io_out_fifo_ram: DEPTH x W storage with one synchronous write port and one asynchronous read port.
module io_out_fifo_ram #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/io_out_fifo.sv
// io_out_fifo: buffers processor output words with their address tag; drops on full and flags overflow.
module io_out_fifo import io_out_fifo_pkg::*; #(
  parameter  int NBMANT = 16,
  parameter  int NBEXPO = 6,
  parameter  int NUIOOU = 2,
  parameter  int DEPTH  = 8,
  localparam int NBD    = nbd_f(NBMANT, NBEXPO),
  localparam int NBA    = nba_f(NUIOOU),
  localparam int NBC    = nbc_f(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           out_en,
  input  logic [NBA-1:0] addr_out,
  input  logic [NBD-1:0] io_out,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [NBA-1:0] m_addr,
  output logic [NBD-1:0] m_data,
  output logic [NBC-1:0] count,
  output logic           full,
  output logic           overflow,
  input  logic           ovf_clr
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [NBA-1:0] tag;
    logic [NBD-1:0] data;
  } ent_t;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NBC-1:0] count_q, count_d;
  logic           ovf_q, ovf_d, push, pop, drop;
  ent_t           wr_ent, rd_ent;
  assign m_valid  = count_q != '0;
  assign full     = count_q == NBC'(DEPTH);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign m_addr   = rd_ent.tag;
  assign m_data   = rd_ent.data;
  assign wr_ent   = '{tag: addr_out, data: io_out};
  always_comb begin
    pop      = m_valid & m_ready;
    push     = out_en & (~full | pop);
    drop     = out_en & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = (push & ~pop) ? count_q + NBC'(1) :
               (pop & ~push) ? count_q - NBC'(1) : count_q;
    // A drop in the same cycle as ovf_clr keeps the flag set.
    ovf_d    = drop | (ovf_q & ~ovf_clr);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  io_out_fifo_ram #(.W(NBA + NBD), .DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_ent),
    .raddr (rd_ptr_q),
    .rdata (rd_ent)
  );
endmodule

// File: tb/tb_io_out_fifo.sv
// tb_io_out_fifo: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_io_out_fifo;
  logic        clk = 0, rst = 0, out_en = 0, m_ready = 0, ovf_clr = 0;
  logic [0:0]  addr_out = '0, m_addr;
  logic [22:0] io_out = '0, m_data;
  logic [3:0]  count;
  logic        m_valid, full, overflow;
  logic [23:0] sb [$];
  logic [23:0] exp_e;
  int total = 0, bad = 0;

  io_out_fifo dut (
    .clk(clk), .rst(rst), .out_en(out_en), .addr_out(addr_out), .io_out(io_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .count(count), .full(full), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [0:0] a, input logic [22:0] d, input bit acc);
    out_en = 1; addr_out = a; io_out = d;
    if (acc) sb.push_back({a, d});
    step();
    out_en = 0;
  endtask

  // Monitor: every accepted head entry must match the oldest expected word.
  always @(negedge clk)
    if (rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_unexpected: got %0h expected none", {m_addr, m_data});
      end else begin
        exp_e = sb.pop_front();
        chk("pop_word", 32'({m_addr, m_data}), 32'(exp_e));
      end
    end

  initial begin
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1;
    step();
    // Single word, held until accepted
    put(1'b1, 23'h2ABCDE, 1);
    chk("sw_valid", 32'(m_valid), 1);
    chk("sw_addr", 32'(m_addr), 1);
    chk("sw_data", 32'(m_data), 32'h2ABCDE);
    chk("sw_count", 32'(count), 1);
    repeat (3) step();
    chk("sw_hold_data", 32'(m_data), 32'h2ABCDE);
    chk("sw_hold_addr", 32'(m_addr), 1);
    m_ready = 1;
    step();
    m_ready = 0;
    chk("sw_empty", 32'(count), 0);
    chk("sw_novalid", 32'(m_valid), 0);
    // Fill to full; the ninth word is dropped
    for (int i = 1; i <= 9; i++) put(1'(i % 2), 23'(i), i <= 8);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    chk("fill_ovf", 32'(overflow), 1);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    chk("clr_ovf", 32'(overflow), 0);
    // Push and pop together while full: pointers wrap, count stays at DEPTH
    m_ready = 1; out_en = 1;
    for (int i = 0; i < 20; i++) begin
      io_out = 23'(100 + i); addr_out = 1'(i % 2);
      sb.push_back({addr_out, io_out});
      step();
      chk("wrap_count", 32'(count), 8);
      chk("wrap_ovf", 32'(overflow), 0);
    end
    m_ready = 0; out_en = 0;
    // Drop coinciding with clear: set wins, then clear alone
    out_en = 1; io_out = 23'd999; ovf_clr = 1;
    step();
    out_en = 0;
    chk("prio_set", 32'(overflow), 1);
    chk("prio_count", 32'(count), 8);
    step();
    ovf_clr = 0;
    chk("prio_clr", 32'(overflow), 0);
    m_ready = 1;
    repeat (8) step();
    m_ready = 0;
    chk("drain_count", 32'(count), 0);
    chk("drain_sb", 32'(sb.size()), 0);
    // Asynchronous reset with five entries stored
    for (int i = 0; i < 5; i++) put(1'b0, 23'(50 + i), 1);
    chk("mid_count", 32'(count), 5);
    #3 rst = 0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_valid", 32'(m_valid), 0);
    chk("ar_ovf", 32'(overflow), 0);
    chk("ar_full", 32'(full), 0);
    sb.delete();
    #2 rst = 1;
    step();
    put(1'b0, 23'h15, 1);
    chk("post_data", 32'(m_data), 32'h15);
    m_ready = 1;
    step();
    m_ready = 0;
    step();
    chk("post_sb", 32'(sb.size()), 0);
    chk("post_count", 32'(count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
